// File: rtl/mem_ctrl_if.sv
// Cache-side line request, writeback and refill bus for mem_ctrl.
// The cache drives through master and the controller responds through slave.
interface mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        wr_done;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;

  modport master (
    output req_valid, req_we, req_addr, wr_valid, wr_data,
    input  req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, wr_valid, wr_data,
    output req_ready, wr_ready, wr_done, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/mem_ctrl.sv
// Four-word line memory controller: refill streams 4 beats, writeback accepts 4 beats.
// Optional MEM_LATENCY_EN inserts a LATENCY-cycle WAIT state before the first beat.
module mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef MEM_LATENCY_EN
    S_WAIT  = 2'd1,
`endif
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    beat, beat_nxt;
  logic [AW-1:0] base, base_nxt;
  logic          wr_done_q, wr_done_nxt;
  logic [29:0]   line_word;
  logic [AW-1:0] word_idx;
  logic          unused_bits;

  logic [31:0] mem [DEPTH_WORDS];

`ifdef MEM_LATENCY_EN
  logic       we_q, we_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
`else
  localparam int unsigned unused_latency = LATENCY;
`endif

  // Word index of the line base; upper bits fall away so lines wrap within memory.
  assign line_word   = {bus.req_addr[31:4], 2'b00};
  assign word_idx    = base + AW'(beat);
  assign unused_bits = ^{line_word[29:AW], bus.req_addr[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      beat      <= '0;
      base      <= '0;
      wr_done_q <= 1'b0;
`ifdef MEM_LATENCY_EN
      we_q      <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      base      <= base_nxt;
      wr_done_q <= wr_done_nxt;
`ifdef MEM_LATENCY_EN
      we_q      <= we_nxt;
      wait_cnt  <= wait_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat;
    base_nxt     = base;
    wr_done_nxt  = 1'b0;
`ifdef MEM_LATENCY_EN
    we_nxt       = we_q;
    wait_cnt_nxt = wait_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          base_nxt     = line_word[AW-1:0];
          beat_nxt     = '0;
`ifdef MEM_LATENCY_EN
          we_nxt       = bus.req_we;
          wait_cnt_nxt = 4'(LATENCY - 1);
          state_nxt    = S_WAIT;
`else
          state_nxt    = bus.req_we ? S_WRITE : S_READ;
`endif
        end
      end
`ifdef MEM_LATENCY_EN
      S_WAIT: begin
        if (wait_cnt == '0) state_nxt = we_q ? S_WRITE : S_READ;
        else                wait_cnt_nxt = wait_cnt - 4'd1;
      end
`endif
      S_READ: begin
        beat_nxt = beat + 2'd1;
        if (beat == 2'd3) state_nxt = S_IDLE;
      end
      S_WRITE: begin
        if (bus.wr_valid) begin
          beat_nxt = beat + 2'd1;
          if (beat == 2'd3) begin
            state_nxt   = S_IDLE;
            wr_done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // No reset on the array: an aborted writeback keeps the beats it already took.
  always_ff @(posedge clk) begin
    if (state == S_WRITE && bus.wr_valid) mem[word_idx] <= bus.wr_data;
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.wr_ready  = (state == S_WRITE);
  assign bus.wr_done   = wr_done_q;
  assign bus.rd_valid  = (state == S_READ);
  assign bus.rd_last   = (state == S_READ) && (beat == 2'd3);
  assign bus.rd_data   = (state == S_READ) ? mem[word_idx] : '0;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: preloads lines by writeback, then checks refills,
// gaps, address wrap, reset abort and continuous request hold.
module tb_mem_ctrl;
`ifdef MEM_LATENCY_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  mem_ctrl_if bus();

  mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < LAT; i++) begin
      check("wait_wr_ready", 32'(bus.wr_ready), 32'd0);
      check("wait_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("wait_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
  endtask

  task automatic read_line(input logic [31:0] addr, input logic [3:0][31:0] exp);
    start_req(1'b0, addr);
    for (int b = 0; b < 4; b++) begin
      check("rd_valid", 32'(bus.rd_valid), 32'd1);
      check("rd_data", bus.rd_data, exp[b]);
      check("rd_last", 32'(bus.rd_last), (b == 3) ? 32'd1 : 32'd0);
      step();
    end
    check("rd_valid_end", 32'(bus.rd_valid), 32'd0);
    check("rd_data_idle", bus.rd_data, 32'd0);
    check("rd_last_end", 32'(bus.rd_last), 32'd0);
    check("req_ready_back", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic write_line(input logic [31:0] addr, input logic [3:0][31:0] d, input int gap);
    start_req(1'b1, addr);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        for (int g = 0; g < gap; g++) begin
          bus.wr_valid = 1'b0;
          check("gap_wr_ready", 32'(bus.wr_ready), 32'd1);
          check("gap_wr_done", 32'(bus.wr_done), 32'd0);
          step();
        end
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = d[b];
      check("wr_ready", 32'(bus.wr_ready), 32'd1);
      check("wr_done_early", 32'(bus.wr_done), 32'd0);
      step();
    end
    bus.wr_valid = 1'b0;
    check("wr_done_pulse", 32'(bus.wr_done), 32'd1);
    check("wr_req_ready", 32'(bus.req_ready), 32'd1);
    check("wr_ready_end", 32'(bus.wr_ready), 32'd0);
    step();
    check("wr_done_single", 32'(bus.wr_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int acc, beats, overlap, wrr, period;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;

    step();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_wr_done", 32'(bus.wr_done), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_last", 32'(bus.rd_last), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Preload mem[16..19] and refill, then the same line with low address bits set
    write_line(32'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0);
    read_line(32'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    read_line(32'h4C, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    // Writeback with a 3-cycle gap after the second beat
    write_line(32'h100, {32'h44, 32'h33, 32'h22, 32'h11}, 3);
    read_line(32'h100, {32'h44, 32'h33, 32'h22, 32'h11});

    // Address wrap modulo DEPTH_WORDS (1024 words = 4 KiB)
    write_line(32'h0, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0);
    read_line(32'h1000, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
    write_line(32'h1010, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1);
    read_line(32'h10, {32'hE3, 32'hE2, 32'hE1, 32'hE0});

    // Reset mid-writeback: two beats land, remaining beats dropped
    write_line(32'h200, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 0);
    start_req(1'b1, 32'h200);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hC0;
    step();
    bus.wr_data  = 32'hC1;
    step();
    bus.wr_data  = 32'hC2;
    rst = 1'b1;
    #1;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("abort_wr_done", 32'(bus.wr_done), 32'd0);
    check("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("abort_rd_last", 32'(bus.rd_last), 32'd0);
    check("abort_rd_data", bus.rd_data, 32'd0);
    step();
    step();
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    check("abort_idle", 32'(bus.req_ready), 32'd1);
    step();
    read_line(32'h200, {32'hB3, 32'hB2, 32'hC1, 32'hC0});

    // req_valid held high with stray wr_valid: one acceptance per transaction
    period = 5 + LAT;
    acc = 0; beats = 0; overlap = 0; wrr = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h40;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 32'hDEAD;
    for (int c = 0; c < 3 * period; c++) begin
      if (bus.req_ready) acc++;
      if (bus.rd_valid) beats++;
      if (bus.req_ready && bus.rd_valid) overlap++;
      if (bus.wr_ready) wrr++;
      step();
    end
    bus.req_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    check("hold_acceptances", 32'(acc), 32'd3);
    check("hold_beats", 32'(beats), 32'd12);
    check("hold_overlap", 32'(overlap), 32'd0);
    check("hold_wr_ready", 32'(wrr), 32'd0);
    check("hold_idle", 32'(bus.req_ready), 32'd1);
    read_line(32'h40, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
